// File: rtl/capture_engine.sv
// Sample-capture core: circular pre-trigger buffer, programmable post-trigger
// tail, then a newest-first, least-significant-byte-first dump to the UART.
module capture_engine #(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2   = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cfg_load,
    input  logic [15:0]             read_count_in,
    input  logic [15:0]             delay_count_in,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    run,
    input  logic                    tx_busy,
    output logic [7:0]              tx_byte,
    output logic                    tx_start,
    output logic                    capturing,
    output logic                    dumping,
    output logic                    done
);

    localparam int unsigned BYTES = SAMPLE_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FillMax = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PtrOne  = 1;
    localparam logic [1:0]            LastIdx = 2'(BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StPost,
        StDumpSetup,
        StDumpRd,
        StDumpTx,
        StDumpGuard
    } state_e;

    state_e                  state_q;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     fill_q;
    logic [15:0]             read_count_q;
    logic [15:0]             delay_count_q;
    logic [15:0]             post_cnt_q;
    logic [15:0]             send_cnt_q;
    logic [1:0]              byte_idx_q;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic                    guard_first_q;
    logic                    load_pending_q;

    logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];
    logic [SAMPLE_WIDTH-1:0] rd_data_q;
    logic                    mem_we;
    logic [15:0]             fill_ext;
    logic [15:0]             send_min;

    // Write whenever a valid sample arrives while capturing; abort wins.
    always_comb begin
        mem_we   = sample_valid && !abort && (state_q == StArmed || state_q == StPost);
        fill_ext = 16'(fill_q);
        send_min = (read_count_q < fill_ext) ? read_count_q : fill_ext;
    end

    // Sample store: one write port, registered read at rd_ptr (no reset, maps to block RAM).
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
        rd_data_q <= mem_q[rd_ptr_q];
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            read_count_q   <= '0;
            delay_count_q  <= '0;
            post_cnt_q     <= '0;
            send_cnt_q     <= '0;
            byte_idx_q     <= '0;
            shift_q        <= '0;
            guard_first_q  <= 1'b0;
            load_pending_q <= 1'b0;
            tx_byte        <= '0;
            tx_start       <= 1'b0;
            capturing      <= 1'b0;
            dumping        <= 1'b0;
            done           <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                state_q   <= StIdle;
                capturing <= 1'b0;
                dumping   <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cfg_load) begin
                            read_count_q  <= read_count_in;
                            delay_count_q <= delay_count_in;
                        end
                        if (arm) begin
                            wr_ptr_q  <= '0;
                            fill_q    <= '0;
                            capturing <= 1'b1;
                            state_q   <= StArmed;
                        end
                    end
                    StArmed: begin
                        if (sample_valid) begin
                            wr_ptr_q <= wr_ptr_q + PtrOne;
                            if (fill_q != FillMax) fill_q <= fill_q + 1'b1;
                            if (run) begin
                                // Use the value latched in IDLE; cfg_load is ignored here.
                                if (delay_count_q == 16'd0) begin
                                    capturing <= 1'b0;
                                    dumping   <= 1'b1;
                                    state_q   <= StDumpSetup;
                                end else begin
                                    post_cnt_q <= delay_count_q;
                                    state_q    <= StPost;
                                end
                            end
                        end
                    end
                    StPost: begin
                        if (sample_valid) begin
                            wr_ptr_q   <= wr_ptr_q + PtrOne;
                            post_cnt_q <= post_cnt_q - 16'd1;
                            if (fill_q != FillMax) fill_q <= fill_q + 1'b1;
                            if (post_cnt_q == 16'd1) begin
                                capturing <= 1'b0;
                                dumping   <= 1'b1;
                                state_q   <= StDumpSetup;
                            end
                        end
                    end
                    StDumpSetup: begin
                        send_cnt_q <= send_min;
                        rd_ptr_q   <= wr_ptr_q - PtrOne;
                        if (send_min == 16'd0) begin
                            dumping <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StDumpRd;
                        end
                    end
                    StDumpRd: begin
                        // rd_data_q holds mem[rd_ptr] one cycle from now.
                        byte_idx_q     <= '0;
                        load_pending_q <= 1'b1;
                        state_q        <= StDumpTx;
                    end
                    StDumpTx: begin
                        if (load_pending_q) begin
                            shift_q        <= rd_data_q;
                            load_pending_q <= 1'b0;
                        end else if (!tx_busy) begin
                            tx_byte       <= shift_q[7:0];
                            tx_start      <= 1'b1;
                            guard_first_q <= 1'b1;
                            state_q       <= StDumpGuard;
                        end
                    end
                    StDumpGuard: begin
                        // First cycle after tx_start: the UART may not have raised busy yet.
                        if (guard_first_q) begin
                            guard_first_q <= 1'b0;
                        end else if (!tx_busy) begin
                            if (byte_idx_q < LastIdx) begin
                                shift_q    <= shift_q >> 8;
                                byte_idx_q <= byte_idx_q + 2'd1;
                                state_q    <= StDumpTx;
                            end else begin
                                send_cnt_q <= send_cnt_q - 16'd1;
                                rd_ptr_q   <= rd_ptr_q - PtrOne;
                                if (send_cnt_q == 16'd1) begin
                                    dumping <= 1'b0;
                                    done    <= 1'b1;
                                    state_q <= StIdle;
                                end else begin
                                    state_q <= StDumpRd;
                                end
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_engine.sv
// Bench for capture_engine: directed scenarios plus randomized captures,
// checked against a sample-history model of what the dump must contain.
module tb_capture_engine;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    always #5 clock = ~clock;

    // 8-bit instance signals
    logic        cfg_load, arm, abort, sample_valid, run, tx_busy;
    logic [15:0] read_count_in, delay_count_in;
    logic [7:0]  sample_in, tx_byte;
    logic        tx_start, capturing, dumping, done;

    // 16-bit instance signals
    logic        w_cfg_load, w_arm, w_abort, w_sample_valid, w_run, w_tx_busy;
    logic [15:0] w_read_count_in, w_delay_count_in, w_sample_in;
    logic [7:0]  w_tx_byte;
    logic        w_tx_start, w_capturing, w_dumping, w_done;

    capture_engine #(.SAMPLE_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_load(cfg_load),
        .read_count_in(read_count_in), .delay_count_in(delay_count_in),
        .arm(arm), .abort(abort), .sample_in(sample_in), .sample_valid(sample_valid),
        .run(run), .tx_busy(tx_busy), .tx_byte(tx_byte), .tx_start(tx_start),
        .capturing(capturing), .dumping(dumping), .done(done)
    );

    capture_engine #(.SAMPLE_WIDTH(16), .DEPTH_LOG2(4)) dut16 (
        .clock(clock), .reset_n(reset_n), .cfg_load(w_cfg_load),
        .read_count_in(w_read_count_in), .delay_count_in(w_delay_count_in),
        .arm(w_arm), .abort(w_abort), .sample_in(w_sample_in),
        .sample_valid(w_sample_valid), .run(w_run), .tx_busy(w_tx_busy),
        .tx_byte(w_tx_byte), .tx_start(w_tx_start), .capturing(w_capturing),
        .dumping(w_dumping), .done(w_done)
    );

    // UART models: busy rises after tx_start and stays high for 10 cycles.
    logic [7:0] rx8[$];
    logic [7:0] rx16[$];
    int done8 = 0, done16 = 0, busy8 = 0, busy16 = 0;

    always @(negedge clock) begin
        if (tx_start) rx8.push_back(tx_byte);
        if (done) done8 <= done8 + 1;
        if (!reset_n) busy8 <= 0;
        else if (tx_start) busy8 <= 10;
        else if (busy8 > 0) busy8 <= busy8 - 1;
    end

    always @(negedge clock) begin
        if (w_tx_start) rx16.push_back(w_tx_byte);
        if (w_done) done16 <= done16 + 1;
        if (!reset_n) busy16 <= 0;
        else if (w_tx_start) busy16 <= 10;
        else if (busy16 > 0) busy16 <= busy16 - 1;
    end

    assign tx_busy   = (busy8 > 0);
    assign w_tx_busy = (busy16 > 0);

    int n_total = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: history of every sample the engine should have stored.
    logic [7:0] hist[$];
    int m_active = 0, m_trig = 0, m_post = 0, m_rd = 0, m_dly = 0, done_base = 0;

    task automatic cfg8(input int rd, input int dly, input bit upd);
        @(negedge clock);
        cfg_load = 1'b1; read_count_in = 16'(rd); delay_count_in = 16'(dly);
        @(negedge clock);
        cfg_load = 1'b0;
        if (upd) begin m_rd = rd; m_dly = dly; end
    endtask

    task automatic arm8();
        @(negedge clock); arm = 1'b1;
        @(negedge clock); arm = 1'b0;
        hist.delete(); rx8.delete();
        done_base = done8; m_active = 1; m_trig = 0;
    endtask

    task automatic feed8(input logic [7:0] v, input bit vld, input bit trg);
        sample_in = v; sample_valid = vld; run = trg;
        @(negedge clock);
        sample_valid = 1'b0; run = 1'b0;
        if (vld && m_active != 0) begin
            hist.push_back(v);
            if (m_trig == 0) begin
                if (trg) begin
                    m_trig = 1;
                    if (m_dly == 0) m_active = 0;
                    else m_post = m_dly;
                end
            end else begin
                m_post--;
                if (m_post == 0) m_active = 0;
            end
        end
    endtask

    task automatic wait_bytes8(input int n);
        for (int i = 0; i < 2000 && rx8.size() < n; i++) @(negedge clock);
    endtask

    // Expected dump: newest min(read, stored) samples, newest first.
    task automatic expect_dump8(input string tag);
        int stored, n;
        logic [7:0] exp_q[$];
        stored = (hist.size() < DEPTH) ? hist.size() : DEPTH;
        n = (m_rd < stored) ? m_rd : stored;
        for (int i = 0; i < n; i++) exp_q.push_back(hist[hist.size() - 1 - i]);
        for (int i = 0; i < 3000 && done8 == done_base; i++) @(negedge clock);
        repeat (30) @(negedge clock);
        check({tag, "_done"}, done8 - done_base, 1);
        check({tag, "_nbytes"}, rx8.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx8.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), rx8[i], exp_q[i]);
    endtask

    initial begin
        reset_n = 1'b0;
        cfg_load = 0; arm = 0; abort = 0; sample_valid = 0; run = 0;
        read_count_in = 0; delay_count_in = 0; sample_in = 0;
        w_cfg_load = 0; w_arm = 0; w_abort = 0; w_sample_valid = 0; w_run = 0;
        w_read_count_in = 0; w_delay_count_in = 0; w_sample_in = 0;
        repeat (3) @(negedge clock);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_outs", {tx_start, capturing, dumping, done}, 0);
        reset_n = 1'b1;

        // Basic capture, with an arm pulse during the dump that must be ignored.
        cfg8(8, 3, 1'b1);
        arm8();
        check("armed_capturing", capturing, 1);
        for (int v = 1; v <= 10; v++) feed8(8'(v), 1'b1, v == 5);
        wait_bytes8(1);
        arm = 1'b1; @(negedge clock); arm = 1'b0;
        @(negedge clock);
        check("arm_in_dump_capturing", capturing, 0);
        check("arm_in_dump_dumping", dumping, 1);
        expect_dump8("basic");
        check("basic_first_byte", rx8.size() > 0 ? rx8[0] : 8'hxx, 8'h08);

        // Wrap, with cfg_load during ARMED that must not change the counts.
        cfg8(16, 0, 1'b1);
        arm8();
        cfg8(1, 5, 1'b0);
        for (int v = 0; v <= 'h27; v++) feed8(8'(v), 1'b1, v == 'h27);
        expect_dump8("wrap");

        // Fill clip.
        cfg8(100, 0, 1'b1);
        arm8();
        for (int v = 0; v < 3; v++) feed8(8'(8'h50 + v), 1'b1, v == 2);
        expect_dump8("clip");

        // 16-bit samples: LSB first, newest first.
        @(negedge clock);
        w_cfg_load = 1; w_read_count_in = 2; w_delay_count_in = 0;
        @(negedge clock); w_cfg_load = 0; w_arm = 1;
        @(negedge clock); w_arm = 0; rx16.delete(); done_base = done16;
        w_sample_in = 16'hA1B2; w_sample_valid = 1;
        @(negedge clock); w_sample_in = 16'hC3D4; w_run = 1;
        @(negedge clock); w_sample_valid = 0; w_run = 0;
        for (int i = 0; i < 2000 && done16 == done_base; i++) @(negedge clock);
        repeat (20) @(negedge clock);
        check("w16_done", done16 - done_base, 1);
        check("w16_nbytes", rx16.size(), 4);
        if (rx16.size() == 4)
            check("w16_bytes", {rx16[0], rx16[1], rx16[2], rx16[3]}, 32'hD4C3B2A1);

        // Abort during the guard after the 2nd byte.
        cfg8(8, 0, 1'b1);
        arm8();
        for (int v = 0; v < 8; v++) feed8(8'(8'h30 + v), 1'b1, v == 7);
        wait_bytes8(2);
        repeat (2) @(negedge clock);
        abort = 1'b1; @(negedge clock); abort = 1'b0;
        repeat (60) @(negedge clock);
        check("abort_nbytes", rx8.size(), 2);
        check("abort_no_done", done8 - done_base, 0);
        check("abort_dumping", dumping, 0);
        cfg8(4, 2, 1'b1);
        arm8();
        for (int v = 0; v < 9; v++) feed8(8'(8'h90 + v), 1'b1, v == 5);
        expect_dump8("after_abort");

        // Asynchronous reset mid-POST.
        cfg8(8, 5, 1'b1);
        arm8();
        for (int v = 0; v < 3; v++) feed8(8'(v), 1'b1, v == 0);
        check("post_capturing", capturing, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_post_tx_byte", tx_byte, 0);
        check("rst_post_outs", {tx_start, capturing, dumping, done}, 0);
        m_active = 0;
        @(negedge clock); reset_n = 1'b1;

        // Randomized captures.
        for (int it = 0; it < 6; it++) begin
            int rd, dly, npre, guard;
            bit vld;
            rd = $urandom_range(0, 20);
            dly = $urandom_range(0, 20);
            npre = $urandom_range(0, 25);
            cfg8(rd, dly, 1'b1);
            arm8();
            for (int i = 0; i < npre; i++) begin
                vld = ($urandom_range(0, 3) != 0);
                feed8(8'($urandom), vld, !vld && ($urandom_range(0, 2) == 0));
            end
            feed8(8'($urandom), 1'b1, 1'b1);
            guard = 0;
            while (m_active != 0 && guard < 200) begin
                feed8(8'($urandom), $urandom_range(0, 2) != 0, 1'($urandom));
                guard++;
            end
            expect_dump8($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/capture_engine.md
Name: capture_engine

Overview:
- Parametrised sample-capture core for the logic analyzer. It sits between the sampler/trigger pair and the UART transmit mux.
- Stores samples in a circular buffer while armed, and stores a programmable number of post-trigger samples once triggered.
- Then streams the capture to the UART as bytes, newest sample first and least-significant byte first.
- Generalises sample width, buffer depth and pre/post-trigger split, none of which were programmable in the first generation.

Parameters:
- SAMPLE_WIDTH, 8, sample bits; must be 8, 16, 24 or 32. BYTES = SAMPLE_WIDTH/8 is derived.
- DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 2**DEPTH_LOG2 samples.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_load  in  1  latch read_count_in/delay_count_in; honoured only in IDLE
- read_count_in  in  16  total samples to send
- delay_count_in  in  16  samples to store after the trigger sample
- arm  in  1  one-cycle pulse, IDLE->ARMED
- abort  in  1  one-cycle pulse, any state->IDLE
- sample_in  in  SAMPLE_WIDTH  data from sampler
- sample_valid  in  1  sample_in valid this cycle
- run  in  1  trigger hit (level)
- tx_busy  in  1  UART busy
- tx_byte  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- capturing  out  1  high in ARMED/POST
- dumping  out  1  high in DUMP states
- done  out  1  one-cycle pulse on return to IDLE after a dump

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, wr_ptr=0, fill=0, read_count=0, delay_count=0. Memory contents are not cleared.
- Memory: DEPTH x SAMPLE_WIDTH, one write port, one synchronous read port, 1-cycle read latency; must infer block RAM.
- IDLE:
  - cfg_load latches both counts.
  - arm resets wr_ptr=0 and fill=0, then enters ARMED next cycle.
  - arm and cfg_load in the same cycle: cfg_load applies first, then arm.
- ARMED:
  - Each sample_valid cycle: write sample_in at wr_ptr; wr_ptr+=1 mod DEPTH; fill saturates at DEPTH.
  - run=1 together with sample_valid: that sample is written and is the trigger sample.
  - After the trigger: delay_count=0 -> DUMP_SETUP; otherwise -> POST with post_cnt=delay_count.
  - run while sample_valid=0 is ignored.
- POST:
  - Each valid sample is written as in ARMED and post_cnt decrements.
  - The write that makes post_cnt reach 0 moves to DUMP_SETUP.
  - run is ignored.
  - delay_count > DEPTH-1 is legal and overwrites the trigger sample; this is not flagged.
- DUMP_SETUP (1 cycle):
  - send_cnt = min(read_count, fill).
  - rd_ptr = wr_ptr-1 mod DEPTH (last written sample).
  - send_cnt=0 -> IDLE with done pulse; otherwise -> DUMP_RD.
- DUMP_RD:
  - Issue a read at rd_ptr; the data is registered into a shift register after 1 cycle.
  - byte_idx=0, then -> DUMP_TX.
- DUMP_TX:
  - When tx_busy=0: tx_byte = shift[7:0], tx_start=1 for one cycle, then -> DUMP_GUARD.
- DUMP_GUARD:
  - The first cycle ignores tx_busy, to cover UART latency.
  - Afterwards, wait for tx_busy=0.
  - Then, if byte_idx < BYTES-1: shift right 8, byte_idx+=1, -> DUMP_TX.
  - Otherwise: send_cnt-=1 and rd_ptr-=1 mod DEPTH. Go to DUMP_RD if send_cnt != 0, or to IDLE with done=1 for one cycle if it is 0.
- Counts: 16-bit unsigned. read_count values above DEPTH are clipped by fill.
- abort:
  - Highest priority; IDLE on the next edge from any state.
  - tx_start is forced 0 that cycle, and a byte already started is not retracted.
  - No done pulse; fill and pointers are kept.
- arm outside IDLE is ignored. cfg_load outside IDLE is ignored.
- Pointer wrap: wr_ptr and rd_ptr wrap naturally at DEPTH_LOG2 bits, in both directions.
- Throughput: no sample is lost in ARMED/POST at sample_valid every cycle.

Test Plan:
- Bench setup: DEPTH_LOG2=4, SAMPLE_WIDTH=8, tx_busy model goes high 1 cycle after tx_start for 10 cycles.
- Basic capture: cfg_load read=8, delay=3; arm; feed 0x01..0x0A every cycle; run with 0x05 -> stores 0x01..0x08; bytes sent 0x08,0x07,...,0x01; done pulse after the 8th byte.
- Wrap: read=16, delay=0; feed 0x00..0x27, trigger on 0x27 -> sends 0x27 down to 0x18 (16 bytes); done once.
- Fill clip: read=100, delay=0; trigger on the 3rd sample after arm -> exactly 3 bytes sent.
- Width: SAMPLE_WIDTH=16, read=2, delay=0; samples 0xA1B2, 0xC3D4 with trigger on the second -> bytes D4,C3,B2,A1.
- Abort: abort during DUMP_GUARD after the 2nd byte -> no further tx_start; done stays 0; a subsequent arm captures normally.
- Reset and ignores: assert reset_n=0 mid-POST -> all outputs 0 within the same cycle. arm pulsed during DUMP -> ignored. cfg_load during ARMED -> counts unchanged.
